alu_operand_loader: RTL and testbench

- Parametrised successor to the switch/button operand-capture front end of the ALU test top.
- Synchronises and debounces the pushbuttons and turns each press into a single-cycle load pulse.
- Captures operand A, operand B and the opcode from the switches, either in any order (free mode) or as a guided sequence driven by one button (sequential mode).
- Registers the ALU result once all three fields are valid, and sits between the board I/O and the combinational ALU.

---
 rtl/alu_operand_loader_if.sv | 29 ++
 rtl/alu_operand_loader.sv | 185 ++++++++++++++++++
 tb/tb_alu_operand_loader.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_operand_loader_if.sv
// Board-side bus of the ALU operand loader: switch/button inputs, the
// combinational ALU result fed back in, and the captured operand/status outputs.
interface alu_operand_loader_if #(
  parameter int BUS_WIDTH = 16,
  parameter int OP_WIDTH  = 6
);
  logic [BUS_WIDTH-1:0] i_switches;
  logic [2:0]           i_pulsador;
  logic [BUS_WIDTH-1:0] i_alu_result;
  logic [BUS_WIDTH-1:0] o_datoA;
  logic [BUS_WIDTH-1:0] o_datoB;
  logic [OP_WIDTH-1:0]  o_opcode;
  logic [BUS_WIDTH-1:0] o_result;
  logic                 o_valid;
  logic [2:0]           o_loaded;
  logic [1:0]           o_state;

  // Board / ALU side: drives switches, buttons and the ALU result.
  modport master (
    output i_switches, i_pulsador, i_alu_result,
    input  o_datoA, o_datoB, o_opcode, o_result, o_valid, o_loaded, o_state
  );

  // Loader side.
  modport slave (
    input  i_switches, i_pulsador, i_alu_result,
    output o_datoA, o_datoB, o_opcode, o_result, o_valid, o_loaded, o_state
  );
endinterface

// File: rtl/alu_operand_loader.sv
// ALU operand loader: synchronises and debounces three pushbuttons, turns each
// accepted press into a one-cycle load pulse, captures A/B/opcode from the
// switches (free order or guided sequence) and registers the ALU result once
// all three fields hold valid data.
module alu_operand_loader #(
  parameter int BUS_WIDTH = 16,
  parameter int OP_WIDTH  = 6,
  parameter int DB_CYCLES = 4,
  parameter int SEQ_MODE  = 0
) (
  input  logic                clk,
  input  logic                reset,
  alu_operand_loader_if.slave bus
);

  localparam int               CNT_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit               SEQ_EN   = (SEQ_MODE != 0);

  typedef enum logic [1:0] {
    S_A   = 2'd0,
    S_B   = 2'd1,
    S_OP  = 2'd2,
    S_RES = 2'd3
  } state_t;

  logic [2:0]           sync1_r;
  logic [2:0]           sync2_r;
  logic [2:0]           db_r;
  logic [2:0]           db_prev_r;
  logic [2:0]           pulse_r;
  logic [CNT_W-1:0]     cnt_r [3];

  state_t               state_r;
  state_t               state_s;
  logic [2:0]           loaded_r;
  logic [2:0]           loaded_s;
  logic [2:0]           load_s;
  logic                 valid_r;
  logic [BUS_WIDTH-1:0] dato_a_r;
  logic [BUS_WIDTH-1:0] dato_b_r;
  logic [OP_WIDTH-1:0]  opcode_r;
  logic [BUS_WIDTH-1:0] result_r;

  // Two-flop synchroniser for the asynchronous pushbuttons.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 3'b000;
      sync2_r <= 3'b000;
    end else begin
      sync1_r <= bus.i_pulsador;
      sync2_r <= sync1_r;
    end
  end

  // Debounce: a level change is accepted after DB_CYCLES consecutive differing cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_r <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2_r[i] != db_r[i]) begin
          if (cnt_r[i] == CNT_LAST) begin
            db_r[i]  <= sync2_r[i];
            cnt_r[i] <= CNT_ZERO;
          end else begin
            cnt_r[i] <= cnt_r[i] + CNT_ONE;
          end
        end else begin
          cnt_r[i] <= CNT_ZERO;
        end
      end
    end
  end

  // Registered rising-edge detect of the debounced levels: one pulse per press.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_prev_r <= 3'b000;
      pulse_r   <= 3'b000;
    end else begin
      db_prev_r <= db_r;
      pulse_r   <= db_r & ~db_prev_r;
    end
  end

  // Load-sequencing state register (stays at S_A in free mode).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_A;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state, per-field load enables and next loaded flags.
  always_comb begin
    state_s  = state_r;
    loaded_s = loaded_r;
    load_s   = 3'b000;
    if (SEQ_EN) begin
      if (pulse_r[1]) begin
        // Restart wins over a simultaneous advance; registers keep contents.
        state_s  = S_A;
        loaded_s = 3'b000;
      end else if (pulse_r[0]) begin
        case (state_r)
          S_A: begin
            load_s   = 3'b001;
            loaded_s = loaded_r | 3'b001;
            state_s  = S_B;
          end
          S_B: begin
            load_s   = 3'b010;
            loaded_s = loaded_r | 3'b010;
            state_s  = S_OP;
          end
          S_OP: begin
            load_s   = 3'b100;
            loaded_s = loaded_r | 3'b100;
            state_s  = S_RES;
          end
          S_RES: begin
            // New round: reload A, B and opcode become stale.
            load_s   = 3'b001;
            loaded_s = 3'b001;
            state_s  = S_B;
          end
          default: begin
            state_s  = S_A;
            loaded_s = 3'b000;
          end
        endcase
      end else begin
        state_s = state_r;
      end
    end else begin
      state_s  = S_A;
      load_s   = pulse_r;
      loaded_s = loaded_r | pulse_r;
    end
  end

  // Operand/opcode capture, flags, valid and the registered ALU result.
  always_ff @(posedge clk) begin
    if (reset) begin
      dato_a_r <= {BUS_WIDTH{1'b0}};
      dato_b_r <= {BUS_WIDTH{1'b0}};
      opcode_r <= {OP_WIDTH{1'b0}};
      result_r <= {BUS_WIDTH{1'b0}};
      loaded_r <= 3'b000;
      valid_r  <= 1'b0;
    end else begin
      if (load_s[0]) begin
        dato_a_r <= bus.i_switches;
      end
      if (load_s[1]) begin
        dato_b_r <= bus.i_switches;
      end
      if (load_s[2]) begin
        opcode_r <= bus.i_switches[OP_WIDTH-1:0];
      end
      // Result follows the ALU only while all fields are valid; otherwise it holds.
      if (valid_r) begin
        result_r <= bus.i_alu_result;
      end
      loaded_r <= loaded_s;
      valid_r  <= &loaded_s;
    end
  end

  assign bus.o_datoA  = dato_a_r;
  assign bus.o_datoB  = dato_b_r;
  assign bus.o_opcode = opcode_r;
  assign bus.o_result = result_r;
  assign bus.o_valid  = valid_r;
  assign bus.o_loaded = loaded_r;
  assign bus.o_state  = state_r;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Testbench for alu_operand_loader: one free-mode and one sequential-mode
// instance share clock, reset, switches and buttons; every cycle both are
// compared with a reference model built from press-acceptance rules.
module tb_alu_operand_loader;

  localparam int BW = 16;
  localparam int OW = 6;
  localparam int DB = 4;
  localparam int HL = 16;

  logic          clk;
  logic          reset;
  logic [BW-1:0] sw;
  logic [2:0]    btn;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [BW-1:0] a;
    logic [BW-1:0] b;
    logic [OW-1:0] op;
    logic [BW-1:0] res;
    logic [2:0]    ld;
    logic          v;
    logic [1:0]    st;
  } mdl_t;

  mdl_t       mf;
  mdl_t       ms;
  logic [2:0] raw_h[$];
  logic [2:0] db_h[$];

  // Reference ALU (MIPS-style function codes).
  function automatic logic [BW-1:0] alu(logic [BW-1:0] a, logic [BW-1:0] b, logic [OW-1:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      default: return 16'h0000;
    endcase
  endfunction

  alu_operand_loader_if #(.BUS_WIDTH(BW), .OP_WIDTH(OW)) fi ();
  alu_operand_loader_if #(.BUS_WIDTH(BW), .OP_WIDTH(OW)) si ();

  assign fi.i_switches   = sw;
  assign fi.i_pulsador   = btn;
  assign fi.i_alu_result = alu(fi.o_datoA, fi.o_datoB, fi.o_opcode);
  assign si.i_switches   = sw;
  assign si.i_pulsador   = btn;
  assign si.i_alu_result = alu(si.o_datoA, si.o_datoB, si.o_opcode);

  alu_operand_loader #(.BUS_WIDTH(BW), .OP_WIDTH(OW), .DB_CYCLES(DB), .SEQ_MODE(0)) dut_free (
    .clk   (clk),
    .reset (reset),
    .bus   (fi)
  );

  alu_operand_loader #(.BUS_WIDTH(BW), .OP_WIDTH(OW), .DB_CYCLES(DB), .SEQ_MODE(1)) dut_seq (
    .clk   (clk),
    .reset (reset),
    .bus   (si)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic mdl_reset();
    raw_h.delete();
    db_h.delete();
    for (int i = 0; i < HL; i++) begin
      raw_h.push_back(3'b000);
      db_h.push_back(3'b000);
    end
    mf = '0;
    ms = '0;
  endtask

  // A button's accepted level flips once its synced input (raw delayed two
  // edges) has disagreed with it for DB consecutive edges; the load happens
  // two edges after the accepted level rises.
  task automatic db_update(output logic [2:0] p);
    logic [2:0] prev;
    logic [2:0] nd;
    bit         all_diff;
    int         n;
    int         m;
    raw_h.push_back(btn);
    n    = raw_h.size();
    prev = db_h[db_h.size()-1];
    nd   = prev;
    for (int i = 0; i < 3; i++) begin
      all_diff = 1'b1;
      for (int k = 0; k < DB; k++) begin
        if (raw_h[n-3-k][i] == prev[i]) all_diff = 1'b0;
      end
      if (all_diff) nd[i] = ~prev[i];
    end
    db_h.push_back(nd);
    m = db_h.size();
    p = db_h[m-3] & ~db_h[m-4];
    void'(raw_h.pop_front());
    void'(db_h.pop_front());
  endtask

  function automatic mdl_t mdl_next(mdl_t cur, logic [2:0] p, logic [BW-1:0] s, bit seq);
    mdl_t n;
    n = cur;
    if (cur.v) n.res = alu(cur.a, cur.b, cur.op);
    if (!seq) begin
      if (p[0]) n.a = s;
      if (p[1]) n.b = s;
      if (p[2]) n.op = s[OW-1:0];
      n.ld = cur.ld | p;
    end else if (p[1]) begin
      n.st = 2'd0;
      n.ld = 3'b000;
    end else if (p[0]) begin
      if (cur.st == 2'd0 || cur.st == 2'd3) n.a = s;
      else if (cur.st == 2'd1) n.b = s;
      else n.op = s[OW-1:0];
      n.ld = (cur.st == 2'd3) ? 3'b001 : (cur.ld | (3'b001 << cur.st));
      n.st = (cur.st == 2'd3) ? 2'd1 : cur.st + 2'd1;
    end
    n.v = &n.ld;
    return n;
  endfunction

  task automatic cmp_inst(string tag, mdl_t e, logic [BW-1:0] a, logic [BW-1:0] b,
                          logic [OW-1:0] op, logic [BW-1:0] res, logic v,
                          logic [2:0] ld, logic [1:0] st);
    chk({tag, "_datoA"},  32'(a),   32'(e.a));
    chk({tag, "_datoB"},  32'(b),   32'(e.b));
    chk({tag, "_opcode"}, 32'(op),  32'(e.op));
    chk({tag, "_result"}, 32'(res), 32'(e.res));
    chk({tag, "_valid"},  32'(v),   32'(e.v));
    chk({tag, "_loaded"}, 32'(ld),  32'(e.ld));
    chk({tag, "_state"},  32'(st),  32'(e.st));
  endtask

  // One clock: sample after the edge, advance the model, compare both DUTs.
  task automatic step();
    logic [2:0] p;
    @(posedge clk);
    #1;
    if (reset) begin
      mdl_reset();
    end else begin
      db_update(p);
      mf = mdl_next(mf, p, sw, 1'b0);
      ms = mdl_next(ms, p, sw, 1'b1);
    end
    cmp_inst("free", mf, fi.o_datoA, fi.o_datoB, fi.o_opcode, fi.o_result,
             fi.o_valid, fi.o_loaded, fi.o_state);
    cmp_inst("seq", ms, si.o_datoA, si.o_datoB, si.o_opcode, si.o_result,
             si.o_valid, si.o_loaded, si.o_state);
  endtask

  task automatic press(logic [2:0] b, logic [BW-1:0] s);
    sw  = s;
    btn = b;
    repeat (DB + 4) step();
    btn = 3'b000;
    repeat (DB + 4) step();
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_f_out"}, 32'({fi.o_datoA, fi.o_datoB}), 32'd0);
    chk({tag, "_f_flags"}, 32'({fi.o_opcode, fi.o_result, fi.o_valid, fi.o_loaded, fi.o_state}), 32'd0);
    chk({tag, "_s_out"}, 32'({si.o_datoA, si.o_datoB}), 32'd0);
    chk({tag, "_s_flags"}, 32'({si.o_opcode, si.o_result, si.o_valid, si.o_loaded, si.o_state}), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    sw    = 16'h0000;
    btn   = 3'b000;
    mdl_reset();

    // Reset then idle with toggling switches.
    repeat (3) step();
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      sw = 16'($urandom);
      step();
    end
    chk_all_zero("idle");

    // Free-mode A load latency and single pulse on a held button.
    sw  = 16'h00A5;
    btn = 3'b001;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 7) chk("a_lat_early", 32'(fi.o_datoA), 32'h0);
      if (k == 8) begin
        chk("a_lat", 32'(fi.o_datoA), 32'h00A5);
        sw = 16'h5A5A;
      end
    end
    btn = 3'b000;
    repeat (10) step();
    chk("a_held", 32'(fi.o_datoA), 32'h00A5);
    chk("a_loaded", 32'(fi.o_loaded), 32'h1);

    // Short glitch on button 1 is rejected.
    btn = 3'b010;
    repeat (3) step();
    btn = 3'b000;
    repeat (10) step();
    chk("b_glitch", 32'(fi.o_datoB), 32'h0);

    // Free-mode full load and result tracking.
    press(3'b001, 16'h0003);
    press(3'b010, 16'h0004);
    sw  = 16'h0020;
    btn = 3'b100;
    for (int k = 1; k <= DB + 4; k++) begin
      step();
      if (k == 7) chk("valid_pre", 32'(fi.o_valid), 32'h0);
      if (k == 8) chk("valid_rise", 32'(fi.o_valid), 32'h1);
    end
    btn = 3'b000;
    step();
    chk("result_add", 32'(fi.o_result), 32'h0007);
    repeat (DB + 3) step();
    sw  = 16'h0005;
    btn = 3'b001;
    for (int k = 1; k <= DB + 5; k++) begin
      step();
      if (k == 8) begin
        chk("a_reload", 32'(fi.o_datoA), 32'h0005);
        chk("result_lag", 32'(fi.o_result), 32'h0007);
      end
      if (k == 9) chk("result_upd", 32'(fi.o_result), 32'h0009);
    end
    btn = 3'b000;
    repeat (DB + 4) step();

    // Simultaneous presses on [0] and [1].
    press(3'b011, 16'h1234);
    chk("sim_a", 32'(fi.o_datoA), 32'h1234);
    chk("sim_b", 32'(fi.o_datoB), 32'h1234);
    chk("seq_restart", 32'(si.o_state), 32'h0);

    // Sequential mode guided load.
    press(3'b001, 16'h0010);
    chk("seq_st1", 32'(si.o_state), 32'h1);
    press(3'b001, 16'h0020);
    chk("seq_st2", 32'(si.o_state), 32'h2);
    press(3'b001, 16'h0024);
    chk("seq_st3", 32'(si.o_state), 32'h3);
    chk("seq_valid", 32'(si.o_valid), 32'h1);
    chk("seq_ops", 32'({si.o_datoA, si.o_datoB}), 32'h00100020);
    chk("seq_op", 32'(si.o_opcode), 32'h24);
    press(3'b001, 16'h0001);
    chk("seq_wrap_a", 32'(si.o_datoA), 32'h0001);
    chk("seq_wrap_st", 32'(si.o_state), 32'h1);
    chk("seq_wrap_valid", 32'(si.o_valid), 32'h0);
    chk("seq_wrap_res", 32'(si.o_result), 32'(alu(16'h0010, 16'h0020, 6'h24)));

    // Restart wins over advance in S_OP.
    press(3'b001, 16'h003F);
    chk("seq_sop", 32'(si.o_state), 32'h2);
    press(3'b011, 16'h0015);
    chk("seq_abort_st", 32'(si.o_state), 32'h0);
    chk("seq_abort_ld", 32'(si.o_loaded), 32'h0);
    chk("seq_abort_op", 32'(si.o_opcode), 32'h24);

    // Reset in the middle of a debounce window.
    sw  = 16'h0077;
    btn = 3'b001;
    repeat (3) step();
    reset = 1'b1;
    step();
    btn = 3'b000;
    step();
    reset = 1'b0;
    repeat (15) step();
    chk_all_zero("rst_mid");

    // Randomised button activity, switches and occasional reset.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 5) == 0) btn[$urandom_range(0, 2)] ^= 1'b1;
      if ($urandom_range(0, 3) == 0) sw = 16'($urandom);
      reset = ($urandom_range(0, 399) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
